seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised Moore-style serial pattern detector: watches a one-bit input stream and flags each occurrence of a compile-time bit pattern of configurable length. It supports overlapping or non-overlapping matching, a per-bit sample enable, and a saturating match counter. It supersedes the fixed five-state 10010 detector in the lab sequence-detection chain. Any pattern and length are set by parameters, and the next-state logic is derived at elaboration time from the pattern's prefix/suffix (failure) function.

## Interface
- N, 5: pattern length in bits; legal range 1..32.
- PATTERN, 5'b10010: pattern bits, N wide; PATTERN[N-1] is the first bit received.
- OVERLAP, 1: 1 = a match's trailing bits may start the next match; 0 = detection restarts from empty after each match.
- CNT_W, 8: match counter width; legal range ≥1.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; w is consumed only on edges where en=1.
- w  in  1  serial data bit.
- clr  in  1  synchronous clear of match_count only.
- z  out  1  Moore match flag; 1 iff progress == N.
- progress  out  $clog2(N+1)  current state: number of pattern bits matched, 0..N.
- match_count  out  CNT_W  number of matches since reset/clr, saturating.

## Operation
- State k = length of the longest suffix of the accepted bit history that equals a prefix of PATTERN (MSB-first), capped at N. There are N+1 states, q0..qN.
- Next state on en=1 with bit w (from state k):
  - k<N: longest j ≤ k+1 such that prefix(j) is a suffix of prefix(k)·w.
  - k=N, OVERLAP=1: same rule applied to the full pattern followed by w (result ≤ N).
  - k=N, OVERLAP=0: treat as k=0, so the next state is (w==PATTERN[N-1]) ? 1 : 0.
- Compute the transition table with an elaboration-time function or generate loop. No hand-enumerated states. Behaviour must be correct for any legal N/PATTERN.
- en=0: state and counter hold; w is ignored.
- z is decoded from registered state only (Moore); it never depends combinationally on w or en.
- match_count:
  - Increments by 1 on each edge where the next state is N and the current edge consumes a bit (en=1).
  - Saturates at 2^CNT_W−1 with no wrap.
- clr=1: match_count becomes 0 on that edge. clr has priority over a simultaneous increment, so that match is not counted. clr does not affect state or z.
- rst=1: progress=0, z=0, match_count=0 immediately, independent of clk. Any partial match is discarded. The first accepted bit after rst deasserts starts from q0.

## Timing
- Latency: z rises in the cycle following the rising edge that samples the final pattern bit. In that same cycle match_count shows the new value.
- With continuous en=1, z is high for exactly one cycle per match. If en stays 0 after a match, z remains high until the next accepted bit.
- Back-to-back overlapping matches are the minimum-distance case: one match per accepted bit is possible only for patterns like all-ones. Each match must produce its own z cycle and counter increment.
- Reset values: z=0, progress=0, match_count=0.
- rst deasserting coincident with a clk edge: that edge must not advance state. The sampled bit is dropped.

## Test plan
- Reset: assert rst mid-stream after bits 1,0,0,1 → progress=0, z=0, match_count=0 without a clk edge. Then feed 0 → no match, progress=0.
- Basic match (defaults): en=1, feed 1,0,0,1,0 → z=1 exactly in the cycle after the 5th edge, match_count=1, progress=5.
- Overlap: feed 1,0,0,1,0,0,1,0 → with OVERLAP=1, z pulses after bits 5 and 8 and match_count=2. With OVERLAP=0, only the bit-5 match occurs and match_count=1.
- Failure transitions: feed 1,1,0,0,1,0 → match after bit 6 (state stays q1 on the repeated 1). Feed 1,0,1,0,0,1,0 → match after bit 7.
- Enable gaps: feed 1,0,0,1,0 with en=0 cycles inserted between bits while w toggles randomly → single match, identical to the gap-free run. z holds high during trailing en=0 cycles.
- Counter: with CNT_W=2, produce 5 matches → match_count=3 (saturated). Assert clr on the same edge as a 6th match → match_count=0 and z=1.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector for an arbitrary N-bit pattern. The next-state table is
// built at elaboration from the pattern's prefix/suffix structure.
//
// state | meaning
// q0    | no pattern prefix is pending
// qk    | the last k accepted bits equal the first k pattern bits (0 < k < N)
// qN    | full pattern just accepted; z=1 until the next accepted bit
module seq_detector_param #(
    parameter int             N       = 5,
    parameter logic [N-1:0]   PATTERN = 5'b10010,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     w,
    input  logic                     clr,
    output logic                     z,
    output logic [$clog2(N+1)-1:0]   progress,
    output logic [CNT_W-1:0]         match_count
);

    localparam int             PW     = $clog2(N+1);
    localparam int             TAB_SZ = 2 ** PW;
    localparam logic [PW-1:0]  LAST   = PW'(N);

    // Longest pattern prefix that is a suffix of prefix(k) followed by bit b.
    function automatic int calc_next(input int k, input logic b);
        logic [32:0] seq;
        int          len;
        int          best;
        logic        ok;
        seq = '0;
        for (int i = 0; i < k; i++) seq[i] = PATTERN[N-1-i];
        seq[k] = b;
        len  = k + 1;
        best = 0;
        for (int j = 1; j <= N; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++)
                    if (seq[len-j+i] != PATTERN[N-1-i]) ok = 1'b0;
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    logic [PW-1:0] nxt_tab0 [TAB_SZ];
    logic [PW-1:0] nxt_tab1 [TAB_SZ];

    for (genvar k = 0; k < TAB_SZ; k++) begin : g_tab
        localparam int KS   = (k >= N && !(k == N && OVERLAP)) ? 0 : k;
        localparam int NXT0 = (k > N) ? 0 : calc_next(KS, 1'b0);
        localparam int NXT1 = (k > N) ? 0 : calc_next(KS, 1'b1);
        assign nxt_tab0[k] = PW'(NXT0);
        assign nxt_tab1[k] = PW'(NXT1);
    end

    logic [PW-1:0] state;
    logic [PW-1:0] state_nxt;
    logic          armed;
    logic          match_inc;

    // armed stays low for the first edge after reset so a bit sampled while
    // rst is releasing can never advance the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        match_inc = 1'b0;
        if (armed && en) begin
            state_nxt = w ? nxt_tab1[state] : nxt_tab0[state];
            match_inc = (state_nxt == LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            match_count <= '0;
        else if (clr)
            match_count <= '0;
        else if (match_inc && (match_count != '1))
            match_count <= match_count + 1'b1;
    end

    assign z        = (state == LAST);
    assign progress = state;

endmodule
